move_ctrl: RTL and testbench
============================

Name: move_ctrl

Overview:
- Turn and move sequencer for the connect-four game.
- Consumes single-cycle enable pulses from three debouncer instances (left, right, drop buttons; each debouncer's SCEN output).
- Tracks the cursor column, the active player and the fill height of each column.
- Issues one handshaked write request per legal drop to the board storage/display block.

Parameters:
- NCOLS, 7, number of board columns.
- NROWS, 6, number of board rows.
- START_COL, 3, cursor column after reset.
- WRAP, 1, 1 = cursor wraps at the edges; 0 = cursor saturates at 0 and NCOLS-1.

Ports:
- CLK  in  1  system clock; all logic rises on posedge.
- RESET  in  1  synchronous, active-high reset.
- LEFT_EN  in  1  one-cycle pulse from the left-button debouncer (SCEN).
- RIGHT_EN  in  1  one-cycle pulse from the right-button debouncer (SCEN).
- DROP_EN  in  1  one-cycle pulse from the drop-button debouncer (SCEN).
- GAME_OVER  in  1  level from the win checker; high blocks all input.
- WR_ACK  in  1  board accepts the write; sampled only while WR_REQ=1.
- COL  out  3  current cursor column, 0..NCOLS-1.
- PLAYER  out  1  player whose turn it is (0 or 1).
- WR_REQ  out  1  write request; held high until acknowledged.
- WR_ROW  out  3  row of the pending write (0 = bottom).
- WR_COL  out  3  column of the pending write.
- WR_PLAYER  out  1  owner of the pending write.
- BUSY  out  1  high while a request is outstanding.
- COL_FULL  out  1  one-cycle pulse when a drop targets a full column.
- BOARD_FULL  out  1  level, high when MOVES = NCOLS*NROWS.
- MOVES  out  6  count of completed drops.

Behaviour:
- Reset values (RESET sampled high at a posedge):
  - COL=START_COL; PLAYER=0.
  - WR_REQ=0, WR_ROW=0, WR_COL=0, WR_PLAYER=0.
  - BUSY=0, COL_FULL=0, BOARD_FULL=0, MOVES=0.
  - All column heights = 0; state = IDLE.
- Reset has priority over every other input. Reset during REQ drops the request: WR_REQ=0 after that edge, and the pending write is discarded.
- State machine has two states, IDLE and REQ. BUSY = (state==REQ).
- IDLE, GAME_OVER=1: all enables are ignored.
- IDLE, GAME_OVER=0, priority DROP_EN > LEFT_EN/RIGHT_EN:
  - DROP_EN with height[COL] < NROWS:
    - Latch WR_ROW=height[COL], WR_COL=COL, WR_PLAYER=PLAYER.
    - WR_REQ=1, state -> REQ.
    - WR_REQ is visible the cycle after the DROP_EN edge.
  - DROP_EN with height[COL] = NROWS: COL_FULL=1 for exactly one cycle. No request is issued and no state change occurs.
  - LEFT_EN alone: COL-1. At COL=0 it goes to NCOLS-1 if WRAP=1, else stays 0.
  - RIGHT_EN alone: COL+1. At COL=NCOLS-1 it goes to 0 if WRAP=1, else stays NCOLS-1.
  - LEFT_EN and RIGHT_EN together: no cursor change.
  - DROP_EN together with LEFT_EN/RIGHT_EN: the drop uses the pre-move COL, and the move is discarded.
- REQ:
  - All enables are ignored and are not queued.
  - WR_* outputs are held stable.
  - GAME_OVER does not cancel an outstanding request.
- REQ, WR_ACK=1 at an edge:
  - WR_REQ=0 after that edge.
  - height[WR_COL] increments.
  - MOVES increments.
  - PLAYER toggles.
  - state -> IDLE.
  - A new drop may be accepted on the following edge, so the minimum drop-to-drop spacing is 2 cycles plus the ACK latency.
  - A zero-latency ACK (WR_ACK=1 on the first REQ cycle) is legal.
- WR_ACK while WR_REQ=0 is ignored.
- BOARD_FULL is combinational from MOVES, compared against the constant NCOLS*NROWS (42).
- MOVES saturates at 42.
- Cursor moves remain legal while BOARD_FULL=1. Every drop then pulses COL_FULL.
- Heights are stored as NCOLS 3-bit registers and never exceed NROWS.

Test Plan:
1. Reset, then LEFT_EN x4 (WRAP=1) -> COL sequence 2,1,0,6. With WRAP=0 -> COL sequence 2,1,0,0.
2. DROP_EN at COL=3, WR_ACK held low for 5 cycles, with LEFT_EN and DROP_EN pulsed during the wait:
   - WR_REQ=1, WR_ROW=0, WR_COL=3, WR_PLAYER=0, held stable for all 5 cycles.
   - The extra pulses are ignored; COL stays 3.
   - On ACK: WR_REQ=0, PLAYER=1, MOVES=1.
3. Six drops on column 0 with immediate ACK -> WR_ROW sequence 0..5 and WR_PLAYER alternating 0,1,0,1,0,1. A seventh drop -> COL_FULL pulses for 1 cycle and WR_REQ stays 0.
4. Simultaneous pulses:
   - DROP_EN+RIGHT_EN at COL=3 -> write to column 3; COL stays 3.
   - LEFT_EN+RIGHT_EN -> COL unchanged.
5. Fill all 42 cells -> BOARD_FULL=1 and MOVES=42. Any further drop -> COL_FULL only.
6. Reset asserted mid-REQ -> next cycle WR_REQ=0, MOVES=0, PLAYER=0, COL=3. A drop at column 0 then gives WR_ROW=0. GAME_OVER=1 in IDLE blocks DROP_EN (no WR_REQ).

Source files
------------

// File: rtl/move_ctrl.sv
// Connect-four turn sequencer: moves the cursor, tracks column fill heights and
// the active player, and issues one handshaked write per legal drop.
module move_ctrl #(
    parameter int NCOLS     = 7,
    parameter int NROWS     = 6,
    parameter int START_COL = 3,
    parameter int WRAP      = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LEFT_EN,
    input  logic       RIGHT_EN,
    input  logic       DROP_EN,
    input  logic       GAME_OVER,
    input  logic       WR_ACK,
    output logic [2:0] COL,
    output logic       PLAYER,
    output logic       WR_REQ,
    output logic [2:0] WR_ROW,
    output logic [2:0] WR_COL,
    output logic       WR_PLAYER,
    output logic       BUSY,
    output logic       COL_FULL,
    output logic       BOARD_FULL,
    output logic [5:0] MOVES
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [2:0] LAST_COL  = 3'(NCOLS - 1);
    localparam logic [2:0] FULL_H    = 3'(NROWS);
    localparam logic [2:0] START     = 3'(START_COL);
    localparam logic [5:0] MAX_MOVES = 6'(NCOLS * NROWS);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_col;
    logic [2:0] w_next_col;
    logic       r_player;
    logic [2:0] r_wr_row;
    logic [2:0] r_wr_col;
    logic       r_wr_player;
    logic       r_col_full;
    logic [5:0] r_moves;
    logic [2:0] r_height [NCOLS];

    logic       w_drop_ok;
    logic       w_drop_full;
    logic       w_ack;
    logic [2:0] w_cur_height;

    assign w_cur_height = r_height[r_col];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_next_col   = r_col;
        w_drop_ok    = 1'b0;
        w_drop_full  = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!GAME_OVER) begin
                    // A drop wins over any simultaneous cursor move, which is discarded.
                    if (DROP_EN) begin
                        if (w_cur_height < FULL_H) begin
                            w_drop_ok    = 1'b1;
                            w_next_state = S_REQ;
                        end else begin
                            w_drop_full = 1'b1;
                        end
                    end else if (LEFT_EN && !RIGHT_EN) begin
                        if (r_col == 3'd0) w_next_col = (WRAP != 0) ? LAST_COL : 3'd0;
                        else               w_next_col = r_col - 3'd1;
                    end else if (RIGHT_EN && !LEFT_EN) begin
                        if (r_col == LAST_COL) w_next_col = (WRAP != 0) ? 3'd0 : LAST_COL;
                        else                   w_next_col = r_col + 3'd1;
                    end
                end
            end
            S_REQ: begin
                if (WR_ACK) begin
                    w_ack        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_col       <= START;
            r_player    <= 1'b0;
            r_wr_row    <= 3'd0;
            r_wr_col    <= 3'd0;
            r_wr_player <= 1'b0;
            r_col_full  <= 1'b0;
            r_moves     <= 6'd0;
            // NOTE: the height array is reset on purpose: a new game must start empty.
            for (int i = 0; i < NCOLS; i++) r_height[i] <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state    <= w_next_state;
            r_col      <= w_next_col;
            r_col_full <= w_drop_full;
            if (w_drop_ok) begin
                r_wr_row    <= w_cur_height;
                r_wr_col    <= r_col;
                r_wr_player <= r_player;
            end
            if (w_ack) begin
                r_height[r_wr_col] <= r_height[r_wr_col] + 3'd1;
                r_player           <= ~r_player;
                if (r_moves != MAX_MOVES) r_moves <= r_moves + 6'd1;
            end
        end
    end

    assign COL        = r_col;
    assign PLAYER     = r_player;
    assign WR_REQ     = (r_state == S_REQ);
    assign BUSY       = (r_state == S_REQ);
    assign WR_ROW     = r_wr_row;
    assign WR_COL     = r_wr_col;
    assign WR_PLAYER  = r_wr_player;
    assign COL_FULL   = r_col_full;
    assign MOVES      = r_moves;
    assign BOARD_FULL = (r_moves == MAX_MOVES);

endmodule

// File: tb/tb_move_ctrl.sv
// Scoreboard bench for move_ctrl: stimulus pushes expected write/column-full
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_move_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       LEFT_EN = 1'b0, RIGHT_EN = 1'b0, DROP_EN = 1'b0;
    logic       GAME_OVER = 1'b0, WR_ACK = 1'b0;
    logic [2:0] COL, WR_ROW, WR_COL;
    logic       PLAYER, WR_REQ, WR_PLAYER, BUSY, COL_FULL, BOARD_FULL;
    logic [5:0] MOVES;

    // Saturating-cursor instance, only its cursor is exercised.
    logic       LEFT2 = 1'b0, RIGHT2 = 1'b0, ZERO = 1'b0;
    logic [2:0] col2, wr_row2, wr_col2;
    logic       player2, wr_req2, wr_player2, busy2, col_full2, board_full2;
    logic [5:0] moves2;

    always #5 CLK = ~CLK;

    move_ctrl #(.NCOLS(7), .NROWS(6), .START_COL(3), .WRAP(1)) dut (
        .CLK(CLK), .RESET(RESET), .LEFT_EN(LEFT_EN), .RIGHT_EN(RIGHT_EN),
        .DROP_EN(DROP_EN), .GAME_OVER(GAME_OVER), .WR_ACK(WR_ACK),
        .COL(COL), .PLAYER(PLAYER), .WR_REQ(WR_REQ), .WR_ROW(WR_ROW),
        .WR_COL(WR_COL), .WR_PLAYER(WR_PLAYER), .BUSY(BUSY),
        .COL_FULL(COL_FULL), .BOARD_FULL(BOARD_FULL), .MOVES(MOVES)
    );

    move_ctrl #(.NCOLS(7), .NROWS(6), .START_COL(3), .WRAP(0)) dut_sat (
        .CLK(CLK), .RESET(RESET), .LEFT_EN(LEFT2), .RIGHT_EN(RIGHT2),
        .DROP_EN(ZERO), .GAME_OVER(ZERO), .WR_ACK(ZERO),
        .COL(col2), .PLAYER(player2), .WR_REQ(wr_req2), .WR_ROW(wr_row2),
        .WR_COL(wr_col2), .WR_PLAYER(wr_player2), .BUSY(busy2),
        .COL_FULL(col_full2), .BOARD_FULL(board_full2), .MOVES(moves2)
    );

    typedef enum logic {EV_REQ, EV_FULL} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [2:0] row;
        logic [2:0] col;
        logic       player;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model of the sequencer state.
    int  m_height[7];
    int  m_col;
    int  m_player;
    int  m_moves;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every request start and column-full pulse against the scoreboard.
    logic prev_req = 1'b0;
    always @(negedge CLK) begin
        ev_t ev;
        if (WR_REQ === 1'b1 && prev_req !== 1'b1) begin
            if (sb.size() == 0) check("unexpected_req", 1, 0);
            else begin
                ev = sb.pop_front();
                check("ev_kind_req", ev.kind, EV_REQ);
                check("wr_row", WR_ROW, ev.row);
                check("wr_col", WR_COL, ev.col);
                check("wr_player", WR_PLAYER, ev.player);
            end
        end
        if (COL_FULL === 1'b1) begin
            if (sb.size() == 0) check("unexpected_col_full", 1, 0);
            else begin
                ev = sb.pop_front();
                check("ev_kind_full", ev.kind, EV_FULL);
            end
        end
        prev_req = WR_REQ;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_height[i] = 0;
        m_col = 3; m_player = 0; m_moves = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic move(input logic l, input logic r);
        LEFT_EN = l; RIGHT_EN = r;
        tick();
        LEFT_EN = 1'b0; RIGHT_EN = 1'b0;
        if (l && !r) m_col = (m_col == 0) ? 6 : m_col - 1;
        else if (r && !l) m_col = (m_col == 6) ? 0 : m_col + 1;
        check("col_after_move", COL, m_col);
    endtask

    // Legal drop at the model cursor; ack after wait_cycles idle REQ cycles.
    task automatic do_drop(input int wait_cycles, input logic with_right);
        ev_t ev;
        ev.kind = EV_REQ; ev.row = 3'(m_height[m_col]); ev.col = 3'(m_col); ev.player = 1'(m_player);
        sb.push_back(ev);
        DROP_EN = 1'b1; RIGHT_EN = with_right;
        tick();
        DROP_EN = 1'b0; RIGHT_EN = 1'b0;
        check("req_set", {BUSY, WR_REQ}, 2'b11);
        repeat (wait_cycles) tick();
        WR_ACK = 1'b1;
        tick();
        WR_ACK = 1'b0;
        m_height[m_col]++;
        m_player ^= 1;
        if (m_moves < 42) m_moves++;
        check("req_clear", WR_REQ, 0);
        check("moves", MOVES, m_moves);
        check("player", PLAYER, m_player);
        check("col_kept", COL, m_col);
    endtask

    task automatic full_drop();
        ev_t ev;
        ev.kind = EV_FULL; ev.row = 3'd0; ev.col = 3'd0; ev.player = 1'b0;
        sb.push_back(ev);
        DROP_EN = 1'b1;
        tick();
        DROP_EN = 1'b0;
        check("full_pulse", COL_FULL, 1);
        check("full_no_req", WR_REQ, 0);
        tick();
        check("full_pulse_end", COL_FULL, 0);
        check("full_moves", MOVES, m_moves);
    endtask

    initial begin
        int exp_l[4];
        int exp_r[7];
        exp_l = '{2, 1, 0, 0};
        exp_r = '{1, 2, 3, 4, 5, 6, 6};

        tick();
        do_reset();
        check("rst_col", COL, 3);
        check("rst_player", PLAYER, 0);
        check("rst_req_busy", {WR_REQ, BUSY}, 0);
        check("rst_wr_fields", {WR_ROW, WR_COL, WR_PLAYER}, 0);
        check("rst_flags", {COL_FULL, BOARD_FULL}, 0);
        check("rst_moves", MOVES, 0);

        // Cursor: wrapping instance and saturating instance.
        for (int i = 0; i < 4; i++) begin
            LEFT2 = 1'b1;
            move(1'b1, 1'b0);
            LEFT2 = 1'b0;
            check("sat_left", col2, exp_l[i]);
        end
        check("wrap_left_end", COL, 6);
        for (int i = 0; i < 7; i++) begin
            RIGHT2 = 1'b1;
            tick();
            RIGHT2 = 1'b0;
            check("sat_right", col2, exp_r[i]);
        end
        repeat (4) move(1'b0, 1'b1);
        check("wrap_right_back", COL, 3);

        // Long wait on ACK with ignored pulses in between.
        begin
            ev_t ev;
            ev.kind = EV_REQ; ev.row = 3'd0; ev.col = 3'd3; ev.player = 1'b0;
            sb.push_back(ev);
        end
        DROP_EN = 1'b1;
        tick();
        DROP_EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            LEFT_EN = (i == 1); DROP_EN = (i == 3);
            check("hold_fields", {WR_REQ, BUSY, WR_ROW, WR_COL, WR_PLAYER}, {1'b1, 1'b1, 3'd0, 3'd3, 1'b0});
            check("hold_col", COL, 3);
            tick();
        end
        LEFT_EN = 1'b0; DROP_EN = 1'b0;
        WR_ACK = 1'b1;
        tick();
        WR_ACK = 1'b0;
        check("t2_req", WR_REQ, 0);
        check("t2_player", PLAYER, 1);
        check("t2_moves", MOVES, 1);
        check("t2_col", COL, 3);
        tick();
        check("t2_no_queued_drop", WR_REQ, 0);

        // Stack column 0 from an empty board, then overflow it.
        do_reset();
        repeat (3) move(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) do_drop(0, 1'b0);
        full_drop();

        // Simultaneous pulses.
        repeat (3) move(1'b0, 1'b1);
        do_drop(1, 1'b1);
        move(1'b1, 1'b1);

        // Fill the remaining cells.
        for (int c = 0; c < 7; c++) begin
            while (m_col != c) move(1'b0, 1'b1);
            while (m_height[c] < 6) begin
                check("not_full_yet", BOARD_FULL, 0);
                do_drop(c % 3, 1'b0);
            end
        end
        check("board_full", BOARD_FULL, 1);
        check("moves_42", MOVES, 42);
        full_drop();
        move(1'b1, 1'b0);
        full_drop();
        check("moves_sat", MOVES, 42);

        // Reset in the middle of a request.
        do_reset();
        begin
            ev_t ev;
            ev.kind = EV_REQ; ev.row = 3'd0; ev.col = 3'd3; ev.player = 1'b0;
            sb.push_back(ev);
        end
        DROP_EN = 1'b1;
        tick();
        DROP_EN = 1'b0;
        check("pre_rst_req", WR_REQ, 1);
        do_reset();
        check("mid_rst", {WR_REQ, BUSY, PLAYER, COL, MOVES}, {1'b0, 1'b0, 1'b0, 3'd3, 6'd0});
        WR_ACK = 1'b1;
        tick();
        WR_ACK = 1'b0;
        check("idle_ack_ignored", MOVES, 0);
        repeat (3) move(1'b1, 1'b0);
        do_drop(0, 1'b0);

        // GAME_OVER blocks everything in IDLE.
        GAME_OVER = 1'b1;
        DROP_EN = 1'b1;
        tick();
        DROP_EN = 1'b0;
        check("go_no_req", WR_REQ, 0);
        LEFT_EN = 1'b1;
        tick();
        LEFT_EN = 1'b0;
        check("go_no_move", COL, 0);
        GAME_OVER = 1'b0;
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
